dmem_ctrl: RTL and testbench

//   Data-memory access controller on the datapath's dmem side. Takes the load/store request
//   (address = ALU result, store data, mem_write) and runs it as one transaction on a

---
 rtl/dmem_ctrl_pkg.sv | 18 +
 rtl/dmem_ctrl_wdog.sv | 31 +++
 rtl/dmem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: FSM state encoding,
// byte-enable constant and watchdog counter width.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } dmem_state_e;

    // Byte-enable pattern for a full-word access; sliced to the bus_be width by the user.
    localparam logic [63:0] DMEM_BE_ALL = '1;

    // Watchdog counter width; covers TIMEOUT up to 2^16-1.
    localparam int unsigned DMEM_WDOG_W = 16;

endpackage

// File: rtl/dmem_ctrl_wdog.sv
// dmem_wdog: transaction timeout counter. Counts while enabled, clears on request,
// saturates at all-ones, flags expiry when the count reaches TIMEOUT-1 while enabled.
module dmem_wdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire_c
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 32'd1);

    logic [CNT_W-1:0] r_cnt;

    // Cycle counter for the current transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire_c = i_en && (r_cnt >= LIMIT);

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: runs a core load/store as one valid/ready bus transaction with a separate
// read-response channel, stalls the core until done and flags timeouts.
// Optional build macro DMEM_ALIGN_CHECK_EN: misaligned accesses are rejected without a
// bus request and reported on misalign; otherwise the low address bits are ignored.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_req,
    input  logic                mem_write,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                stall,
    output logic                err,
    output logic                misalign,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    dmem_state_e        r_state;
    dmem_state_e        w_state_nxt;
    logic               r_bus_valid;
    logic               r_bus_we;
    logic [ADDR_W-1:0]  r_bus_addr;
    logic [DATA_W-1:0]  r_bus_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_err;
    logic               r_misalign;

    logic               w_valid_nxt;
    logic               w_we_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [DATA_W-1:0]  w_wdata_nxt;
    logic [DATA_W-1:0]  w_rdata_nxt;
    logic               w_err_nxt;
    logic               w_misalign_nxt;
    logic               w_misaligned;
    logic [ADDR_W-1:0]  w_addr_aligned;
    logic               w_wd_clr;
    logic               w_wd_en;
    logic               w_expire;

    assign w_addr_aligned = addr & ~ADDR_W'(3);

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misaligned = (addr[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_wd_clr = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_wd_en  = (r_state == S_REQ)  || (r_state == S_RESP);

    dmem_wdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (DMEM_WDOG_W)
    ) u_wdog (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_wd_clr),
        .i_en       (w_wd_en),
        .o_expire_c (w_expire)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next register values; completion takes priority over timeout.
    always_comb begin
        w_state_nxt    = r_state;
        w_valid_nxt    = 1'b0;
        w_we_nxt       = r_bus_we;
        w_addr_nxt     = r_bus_addr;
        w_wdata_nxt    = r_bus_wdata;
        w_rdata_nxt    = r_rdata;
        w_err_nxt      = 1'b0;
        w_misalign_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_req) begin
                    if (w_misaligned) begin
                        w_state_nxt    = S_DONE;
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_valid_nxt = 1'b1;
                        w_we_nxt    = mem_write;
                        w_addr_nxt  = w_addr_aligned;
                        w_wdata_nxt = wdata;
                    end
                end
            end
            S_REQ: begin
                if (bus_ready) begin
                    w_state_nxt = r_bus_we ? S_DONE : S_RESP;
                end else if (w_expire) begin
                    w_state_nxt = S_DONE;
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_valid_nxt = 1'b1;
                end
            end
            S_RESP: begin
                if (bus_rvalid) begin
                    w_state_nxt = S_DONE;
                    w_rdata_nxt = bus_rdata;
                end else if (w_expire) begin
                    w_state_nxt = S_DONE;
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus request, load data and status pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_bus_valid <= w_valid_nxt;
            r_bus_we    <= w_we_nxt;
            r_bus_addr  <= w_addr_nxt;
            r_bus_wdata <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_err       <= w_err_nxt;
            r_misalign  <= w_misalign_nxt;
        end
    end

    assign stall     = ((r_state == S_IDLE) && mem_req) || (r_state == S_REQ) || (r_state == S_RESP);
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign misalign  = r_misalign;
    assign bus_valid = r_bus_valid;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_be    = DMEM_BE_ALL[BE_W-1:0];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus pushes expected bus requests and completion
// records; a monitor pops and compares when the DUT presents them.
module tb_dmem_ctrl;

    localparam int unsigned TO = 8;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;
    logic        misalign;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    dmem_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .err        (err),
        .misalign   (misalign),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          vcyc;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        int          scyc;
    } done_exp_t;

    bus_exp_t    bus_q[$];
    done_exp_t   done_q[$];
    int          n_cmp;
    int          n_bad;
    bit          mon_en;
    bit          skip_done;
    logic [31:0] exp_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next cycle; inputs change shortly after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step();
        mem_req   = 1'b0;
        mem_write = 1'b0;
        addr      = $urandom;
        wdata     = $urandom;
    endtask

    // One core access; returns while the DUT sits in its completion cycle with mem_req still high.
    task automatic do_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input int rdy_dly, input int rv_dly, input logic [31:0] rd,
                             input bit never_rdy);
        bus_exp_t  b;
        done_exp_t d;
        bit        mis;
        mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`endif
        b.we    = we;
        b.addr  = a & 32'hFFFF_FFFC;
        b.wdata = wd;
        b.vcyc  = never_rdy ? int'(TO) : rdy_dly + 1;
        d.err   = never_rdy && !mis;
        d.mis   = mis;
        if (mis) begin
            d.scyc = 1;
        end else if (never_rdy) begin
            d.scyc    = 1 + int'(TO);
            exp_rdata = 32'h0;
        end else if (we) begin
            d.scyc = rdy_dly + 2;
        end else begin
            d.scyc    = 2 + rdy_dly + rv_dly;
            exp_rdata = rd;
        end
        d.rdata = exp_rdata;
        if (!mis) bus_q.push_back(b);
        done_q.push_back(d);

        step();
        mem_req   = 1'b1;
        mem_write = we;
        addr      = a;
        wdata     = wd;
        step();
        if (mis) return;
        if (never_rdy) begin
            repeat (TO) step();
            return;
        end
        repeat (rdy_dly) step();
        bus_ready = 1'b1;
        if (!we) begin
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hBAD0_0BAD;
        end
        step();
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = $urandom;
        if (!we) begin
            repeat (rv_dly - 1) step();
            bus_rvalid = 1'b1;
            bus_rdata  = rd;
            step();
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom;
        end
    endtask

    // Monitor: bus request fields/length and completion records, sampled mid-cycle.
    bus_exp_t  cur_b;
    done_exp_t cur_d;
    int        v_cnt;
    int        s_cnt;
    logic      prev_valid;
    logic      prev_stall;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_valid) begin
                if (bus_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL bus_unexpected: got bus_valid=1 addr=0x%08h, want no request", bus_addr);
                end else begin
                    cur_b = bus_q[0];
                    check("bus_we", 32'(bus_we), 32'(cur_b.we));
                    check("bus_addr", bus_addr, cur_b.addr);
                    check("bus_wdata", bus_wdata, cur_b.wdata);
                    check("bus_be", 32'(bus_be), 32'hF);
                end
                v_cnt++;
            end else if (prev_valid) begin
                if (bus_q.size() != 0) begin
                    cur_b = bus_q.pop_front();
                    check("bus_valid_cycles", v_cnt, cur_b.vcyc);
                end
                v_cnt = 0;
            end

            if (stall) begin
                s_cnt++;
                check("pulse_outside_done", 32'({err, misalign}), 32'h0);
            end else if (prev_stall) begin
                if (skip_done) begin
                    skip_done = 1'b0;
                end else if (done_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_unexpected: got completion, want none");
                end else begin
                    cur_d = done_q.pop_front();
                    check("done_rdata", rdata, cur_d.rdata);
                    check("done_err", 32'(err), 32'(cur_d.err));
                    check("done_misalign", 32'(misalign), 32'(cur_d.mis));
                    check("stall_cycles", s_cnt, cur_d.scyc);
                end
                s_cnt = 0;
            end else begin
                check("pulse_outside_done", 32'({err, misalign}), 32'h0);
            end
        end
        prev_valid = bus_valid;
        prev_stall = stall;
    end

    initial begin
        bus_exp_t b;
        n_cmp      = 0;
        n_bad      = 0;
        mon_en     = 1'b0;
        skip_done  = 1'b0;
        exp_rdata  = 32'h0;
        v_cnt      = 0;
        s_cnt      = 0;
        rst        = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        addr       = 32'h0;
        wdata      = 32'h0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("rst_bus_valid", 32'(bus_valid), 32'h0);
        check("rst_bus_we", 32'(bus_we), 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_misalign", 32'(misalign), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        prev_valid = bus_valid;
        prev_stall = stall;
        mon_en     = 1'b1;

        // Store with ready already high.
        do_access(1'b1, 32'h0000_0010, 32'hCAFE_BABE, 0, 0, 32'h0, 1'b0);
        idle();
        // Load: ready after 3 waiting cycles, response 2 cycles after acceptance.
        do_access(1'b0, 32'h0000_0024, 32'h0, 3, 2, 32'h1234_5678, 1'b0);
        idle();
        // Minimum-latency load.
        do_access(1'b0, 32'h0000_0030, 32'h0, 0, 1, 32'h8765_4321, 1'b0);
        idle();
        // Timeout: ready never asserted, then a normal store.
        do_access(1'b0, 32'h0000_0040, 32'h0, 0, 0, 32'h0, 1'b1);
        idle();
        do_access(1'b1, 32'h0000_0044, 32'h0BAD_F00D, 1, 0, 32'h0, 1'b0);
        idle();
        // Back-to-back load then store, mem_req held through the completion cycle.
        do_access(1'b0, 32'h0000_0100, 32'h0, 0, 1, 32'hA5A5_0F0F, 1'b0);
        do_access(1'b1, 32'h0000_0104, 32'h600D_CAFE, 2, 0, 32'h0, 1'b0);
        idle();

        // Reset while waiting for a read response, then a stray response in IDLE.
        b.we    = 1'b0;
        b.addr  = 32'h0000_0200;
        b.wdata = 32'h0;
        b.vcyc  = 1;
        bus_q.push_back(b);
        step();
        mem_req   = 1'b1;
        mem_write = 1'b0;
        addr      = 32'h0000_0200;
        wdata     = 32'h0;
        step();
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        mem_req   = 1'b0;
        skip_done = 1'b1;
        rst       = 1'b0;
        step();
        rst        = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h7777_7777;
        @(negedge clk);
        check("post_rst_rdata", rdata, 32'h0);
        check("post_rst_bus_valid", 32'(bus_valid), 32'h0);
        check("post_rst_stall", 32'(stall), 32'h0);
        step();
        bus_rvalid = 1'b0;
        @(negedge clk);
        check("stray_rvalid_rdata", rdata, 32'h0);
        check("stray_rvalid_bus_valid", 32'(bus_valid), 32'h0);
        exp_rdata = 32'h0;

        // Misaligned load and store.
        do_access(1'b0, 32'h0000_0013, 32'h0, 0, 1, 32'h1357_9BDF, 1'b0);
        idle();
        do_access(1'b1, 32'h0000_0022, 32'h2468_ACE0, 0, 0, 32'h0, 1'b0);
        idle();
        do_access(1'b0, 32'h0000_0300, 32'h0, 1, 3, 32'hFEED_0001, 1'b0);
        idle();

        repeat (4) idle();
        check("bus_q_drained", bus_q.size(), 32'h0);
        check("done_q_drained", done_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
